// File: rtl/accum_seq.sv
// accum_seq: counted unsigned accumulator with valid/ready operand and result ports.
// Optional ACCUM_SAT_EN: saturate the sum to all-ones on carry-out instead of wrapping.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // carries generated in parallel from slice generate/propagate terms
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

module accum_seq #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic              busy
);

  localparam int NS = DATA_W / 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic              flag;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] sum;
  logic [NS:0]       rc;
  logic [DATA_W-1:0] acc_nxt;

  assign rc[0] = 1'b0;

  // ripple of 4-bit lookahead slices forms the accumulator adder
  for (genvar i = 0; i < NS; i++) begin : g_slice
    cla4 u_cla (
      .a  (acc[4*i +: 4]),
      .b  (in_data[4*i +: 4]),
      .ci (rc[i]),
      .s  (sum[4*i +: 4]),
      .co (rc[i+1])
    );
  end

`ifdef ACCUM_SAT_EN
  // once any carry has occurred in the run the sum pins at all-ones
  assign acc_nxt = (flag | rc[NS]) ? {DATA_W{1'b1}} : sum;
`else
  assign acc_nxt = sum;
`endif

  assign out_sum   = acc;
  assign out_carry = flag;

  // control FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      flag      <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            flag <= 1'b0;
            busy <= 1'b1;
            if (len != '0) begin
              cnt      <= len;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc  <= acc_nxt;
            flag <= flag | rc[NS];
            cnt  <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: directed runs with a result scoreboard for accum_seq.
// Expected results are queued at stimulus time and checked by a monitor.
module tb_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        busy;

  int nvec = 0;
  int nmis = 0;
  logic [16:0] exp_q[$];

  accum_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every cycle a result is shown it must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_sum", 32'(out_sum), 32'(exp_q[0][15:0]));
        chk("out_carry", 32'(out_carry), 32'(exp_q[0][16]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    int t;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 20) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!busy && !out_valid) break;
      t++;
      if (t > 40) begin
        chk(nm, 32'(busy), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // three operands back-to-back, one-cycle result latency
    exp_q.push_back({1'b0, 16'h0006});
    do_start(8'd3);
    send(16'h0001, 0);
    send(16'h0002, 0);
    send(16'h0003, 0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    wait_idle("idle_after_len3");

    // carry out of the top bit
`ifdef ACCUM_SAT_EN
    exp_q.push_back({1'b1, 16'hFFFF});
`else
    exp_q.push_back({1'b1, 16'h0001});
`endif
    do_start(8'd2);
    send(16'hFFFF, 0);
    send(16'h0002, 0);
    wait_idle("idle_after_carry");

    // gaps on the input, result held while downstream stalls
    exp_q.push_back({1'b0, 16'h00A0});
    do_start(8'd4);
    send(16'h0010, 0);
    send(16'h0020, 1);
    send(16'h0030, 2);
    out_ready = 1'b0;
    send(16'h0040, 3);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_q_pending", 32'(exp_q.size()), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ret_out_valid", 32'(out_valid), 32'd0);
    chk("ret_busy", 32'(busy), 32'd0);
    chk("ret_hold_sum", 32'(out_sum), 32'h00A0);

    // zero-length run goes straight to DONE
    exp_q.push_back({1'b0, 16'h0000});
    do_start(8'd0);
    @(negedge clk);
    chk("len0_out_valid", 32'(out_valid), 32'd1);
    chk("len0_in_ready", 32'(in_ready), 32'd0);
    wait_idle("idle_after_len0");

    // reset in the middle of a run discards it
    do_start(8'd5);
    send(16'h1111, 0);
    send(16'h2222, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
    #3;
    rst = 1'b0;
    exp_q.push_back({1'b0, 16'h00AA});
    do_start(8'd1);
    send(16'h00AA, 0);
    wait_idle("idle_after_rst");

    // start pulses inside ACCUM and DONE are ignored
    exp_q.push_back({1'b0, 16'h0012});
    do_start(8'd3);
    send(16'h0005, 0);
    start = 1'b1;
    len   = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    send(16'h0006, 0);
    out_ready = 1'b0;
    send(16'h0007, 0);
    start = 1'b1;
    len   = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_ign_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_idle("idle_after_ign");

    // longest run, count must not wrap
    exp_q.push_back({1'b0, 16'h01FE});
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send(16'h0002, 0);
    @(negedge clk);
    chk("max_out_valid", 32'(out_valid), 32'd1);
    wait_idle("idle_after_max");

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
